// File: rtl/qeciphy_multilane_resetsequencer_if.sv
// Signal bundle between the multilane reset sequencer and its surrounding top level.
// The slave modport is the sequencer's view; the master modport is the top level's view.
interface qeciphy_multilane_resetsequencer_if #(
  parameter int NUM_LANES   = 4,
  parameter int MAX_RETRIES = 3
);
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic                 gt_power_good_i;
  logic [NUM_LANES-1:0] lane_enable_i;
  logic [NUM_LANES-1:0] gt_tx_rst_done_i;
  logic [NUM_LANES-1:0] gt_rx_rst_done_i;
  logic                 soft_rst_req_i;
  logic [NUM_LANES-1:0] gt_rst_n_o;
  logic                 datapath_rst_n_o;
  logic                 rst_done_o;
  logic                 rst_fail_o;
  logic [NUM_LANES-1:0] lane_fault_o;
  logic [RC_W-1:0]      retry_count_o;
  logic [2:0]           state_o;

  modport master (
    output gt_power_good_i, lane_enable_i, gt_tx_rst_done_i, gt_rx_rst_done_i, soft_rst_req_i,
    input  gt_rst_n_o, datapath_rst_n_o, rst_done_o, rst_fail_o, lane_fault_o, retry_count_o, state_o
  );

  modport slave (
    input  gt_power_good_i, lane_enable_i, gt_tx_rst_done_i, gt_rx_rst_done_i, soft_rst_req_i,
    output gt_rst_n_o, datapath_rst_n_o, rst_done_o, rst_fail_o, lane_fault_o, retry_count_o, state_o
  );
endinterface

// File: rtl/qeciphy_multilane_resetsequencer.sv
// Per-lane GT and datapath reset sequencer with GT-done timeout, bounded retry,
// lane-drop recovery, power-good loss handling and soft restart. Single AXIS clock.
module qeciphy_multilane_resetsequencer #(
  parameter int NUM_LANES             = 4,
  parameter int GT_DELAY_CYCLES       = 1250,
  parameter int DATAPATH_DELAY_CYCLES = 32,
  parameter int GT_DONE_TIMEOUT       = 65535,
  parameter int MAX_RETRIES           = 3
) (
  input logic                             axis_clk_i,
  input logic                             axis_rst_n_i,
  qeciphy_multilane_resetsequencer_if.slave bus
);

  localparam int MAX_CNT =
    (GT_DELAY_CYCLES > DATAPATH_DELAY_CYCLES)
      ? ((GT_DELAY_CYCLES > GT_DONE_TIMEOUT) ? GT_DELAY_CYCLES : GT_DONE_TIMEOUT)
      : ((DATAPATH_DELAY_CYCLES > GT_DONE_TIMEOUT) ? DATAPATH_DELAY_CYCLES : GT_DONE_TIMEOUT);
  localparam int CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] GT_DLY_LD = CNT_W'(GT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] DP_DLY_LD = CNT_W'(DATAPATH_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(GT_DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_MAX    = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET        = 3'd0,
    ST_WAIT_PWRGOOD = 3'd1,
    ST_GT_DELAY     = 3'd2,
    ST_WAIT_GT_DONE = 3'd3,
    ST_DP_DELAY     = 3'd4,
    ST_DONE         = 3'd5,
    ST_FAIL         = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] lane_mask_q, lane_mask_d;
  logic [NUM_LANES-1:0] lane_fault_q, lane_fault_d;
  logic [RC_W-1:0]      retry_q, retry_d;
  logic                 done_q, done_d;

  logic [NUM_LANES-1:0] lane_ok;
  logic [NUM_LANES-1:0] lane_bad;
  logic                 all_ok;
  logic                 pg_lost;
  logic                 take_retry;

  // Masked-off lanes count as healthy, so an empty mask is trivially all_ok.
  assign lane_ok  = bus.gt_tx_rst_done_i & bus.gt_rx_rst_done_i;
  assign lane_bad = lane_mask_q & ~lane_ok;
  assign all_ok   = &(lane_ok | ~lane_mask_q);
  assign pg_lost  = !bus.gt_power_good_i &&
                    (state_q inside {ST_GT_DELAY, ST_WAIT_GT_DONE, ST_DP_DELAY, ST_DONE});

  always_comb begin
    // NOTE: every target gets its hold value first so no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_mask_d  = lane_mask_q;
    lane_fault_d = lane_fault_q;
    retry_d      = retry_q;
    take_retry   = 1'b0;

    if (bus.soft_rst_req_i) begin
      state_d      = ST_RESET;
      cnt_d        = '0;
      lane_mask_d  = '0;
      lane_fault_d = '0;
      retry_d      = '0;
    end else if (pg_lost) begin
      state_d = ST_WAIT_PWRGOOD;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_WAIT_PWRGOOD;
        ST_WAIT_PWRGOOD: begin
          if (bus.gt_power_good_i) begin
            state_d     = ST_GT_DELAY;
            lane_mask_d = bus.lane_enable_i;
            cnt_d       = GT_DLY_LD;
          end
        end
        ST_GT_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_GT_DONE;
            cnt_d   = TMO_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_WAIT_GT_DONE: begin
          if (all_ok) begin
            state_d = ST_DP_DELAY;
            cnt_d   = DP_DLY_LD;
          end else if (cnt_q == '0) begin
            lane_fault_d = lane_bad;
            take_retry   = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DP_DELAY: begin
          if (!all_ok) begin
            lane_fault_d = lane_bad;
            take_retry   = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (!all_ok) begin
            lane_fault_d = lane_bad;
            take_retry   = 1'b1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RESET;
      endcase

      // Shared by timeout and in-service drop: re-run GT bring-up or give up.
      if (take_retry) begin
        if (retry_q < RC_MAX) begin
          retry_d     = retry_q + RC_ONE;
          state_d     = ST_GT_DELAY;
          cnt_d       = GT_DLY_LD;
          lane_mask_d = bus.lane_enable_i;
        end else begin
          state_d = ST_FAIL;
        end
      end
    end

    // rst_done trails datapath release by one cycle but drops with it.
    done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  always_ff @(posedge axis_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!axis_rst_n_i) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      lane_mask_q  <= '0;
      lane_fault_q <= '0;
      retry_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_mask_q  <= lane_mask_d;
      lane_fault_q <= lane_fault_d;
      retry_q      <= retry_d;
      done_q       <= done_d;
    end
  end

  assign bus.gt_rst_n_o       = (state_q inside {ST_WAIT_GT_DONE, ST_DP_DELAY, ST_DONE})
                                ? lane_mask_q : '0;
  assign bus.datapath_rst_n_o = (state_q == ST_DONE);
  assign bus.rst_done_o       = done_q;
  assign bus.rst_fail_o       = (state_q == ST_FAIL);
  assign bus.lane_fault_o     = lane_fault_q;
  assign bus.retry_count_o    = retry_q;
  assign bus.state_o          = state_q;

endmodule

// File: tb/tb_qeciphy_multilane_resetsequencer.sv
// Bench for the multilane reset sequencer: directed bring-up scenarios followed by a
// randomized soak, every cycle compared against a phase-based reference model.
module tb_qeciphy_multilane_resetsequencer;

  localparam int NL   = 4;
  localparam int GTD  = 10;
  localparam int DPD  = 4;
  localparam int TO   = 20;
  localparam int MR   = 2;
  localparam int RC_W = (MR > 0) ? $clog2(MR + 1) : 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qeciphy_multilane_resetsequencer_if #(.NUM_LANES(NL), .MAX_RETRIES(MR)) bus ();

  qeciphy_multilane_resetsequencer #(
    .NUM_LANES(NL), .GT_DELAY_CYCLES(GTD), .DATAPATH_DELAY_CYCLES(DPD),
    .GT_DONE_TIMEOUT(TO), .MAX_RETRIES(MR)
  ) dut (
    .axis_clk_i   (clk),
    .axis_rst_n_i (rst_n),
    .bus          (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase code, cycles already spent in the phase, and bookkeeping.
  int          m_st, m_age, m_retry;
  logic [NL-1:0] m_mask, m_fault;

  // GT emulation: per-lane bring-up latency and lanes that never report done.
  int          up_cnt [NL];
  int          lat    [NL];
  logic [NL-1:0] stuck_tx, stuck_rx;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic [2:0] st, input logic [RC_W-1:0] rc,
                                       input logic [NL-1:0] flt, input logic fail,
                                       input logic done, input logic dp, input logic [NL-1:0] gt);
    return 32'({st, rc, flt, fail, done, dp, gt});
  endfunction

  function automatic logic [NL-1:0] exp_gt();
    return (m_st >= 3 && m_st <= 5) ? m_mask : '0;
  endfunction

  function automatic logic [31:0] exp_vec();
    return pack(3'(m_st), RC_W'(m_retry), m_fault, (m_st == 6), (m_st == 5 && m_age >= 1),
                (m_st == 5), exp_gt());
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(bus.state_o, bus.retry_count_o, bus.lane_fault_o, bus.rst_fail_o,
                bus.rst_done_o, bus.datapath_rst_n_o, bus.gt_rst_n_o);
  endfunction

  task automatic enter_phase(input int s);
    m_st  = s;
    m_age = 0;
  endtask

  task automatic model_retry();
    if (m_retry < MR) begin
      m_retry++;
      m_mask = bus.lane_enable_i;
      enter_phase(2);
    end else begin
      enter_phase(6);
    end
  endtask

  task automatic model_step();
    logic [NL-1:0] ok;
    logic          all_ok;
    ok     = bus.gt_tx_rst_done_i & bus.gt_rx_rst_done_i;
    all_ok = ((ok | ~m_mask) == '1);
    if (!rst_n || bus.soft_rst_req_i) begin
      enter_phase(0);
      m_mask  = '0;
      m_fault = '0;
      m_retry = 0;
    end else if (!bus.gt_power_good_i && m_st >= 2 && m_st <= 5) begin
      enter_phase(1);
    end else begin
      case (m_st)
        0: enter_phase(1);
        1: if (bus.gt_power_good_i) begin
             m_mask = bus.lane_enable_i;
             enter_phase(2);
           end
        2: if (m_age == GTD - 1) enter_phase(3); else m_age++;
        3: if (all_ok) enter_phase(4);
           else if (m_age == TO - 1) begin
             m_fault = m_mask & ~ok;
             model_retry();
           end else m_age++;
        4: if (!all_ok) begin
             m_fault = m_mask & ~ok;
             model_retry();
           end else if (m_age == DPD - 1) enter_phase(5);
           else m_age++;
        5: if (!all_ok) begin
             m_fault = m_mask & ~ok;
             model_retry();
           end else m_age++;
        default: ;
      endcase
    end
  endtask

  task automatic gt_emulate();
    logic [NL-1:0] g;
    logic          ready;
    g = exp_gt();
    for (int i = 0; i < NL; i++) begin
      if (!g[i]) up_cnt[i] = 0;
      else if (up_cnt[i] < 1000) up_cnt[i]++;
      ready = g[i] && (up_cnt[i] >= lat[i]);
      bus.gt_tx_rst_done_i[i] = ready && !stuck_tx[i];
      bus.gt_rx_rst_done_i[i] = ready && !stuck_rx[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", dut_vec(), exp_vec());
    bus.soft_rst_req_i = 1'b0;
    gt_emulate();
  endtask

  task automatic wait_state(input int code, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.state_o !== 3'(code) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.state_o), 32'(code));
  endtask

  task automatic soft_pulse();
    bus.soft_rst_req_i = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                = 1'b0;
    bus.gt_power_good_i  = 1'b0;
    bus.lane_enable_i    = '1;
    bus.gt_tx_rst_done_i = '0;
    bus.gt_rx_rst_done_i = '0;
    bus.soft_rst_req_i   = 1'b0;
    stuck_tx = '0;
    stuck_rx = '0;
    for (int i = 0; i < NL; i++) begin
      lat[i]    = 3;
      up_cnt[i] = 0;
    end
    m_st = 0; m_age = 0; m_retry = 0; m_mask = '0; m_fault = '0;

    repeat (3) tick();
    check("reset_outs", dut_vec(), 32'h0);

    // Nominal bring-up, all four lanes.
    rst_n = 1'b1;
    bus.gt_power_good_i = 1'b1;
    wait_state(2, 10, "nom_gt_delay");
    repeat (GTD - 1) tick();
    check("nom_gt_hold", 32'(bus.gt_rst_n_o), 32'h0);
    tick();
    check("nom_gt_rise", 32'(bus.gt_rst_n_o), 32'hF);
    wait_state(4, 40, "nom_dp_delay");
    repeat (DPD - 1) tick();
    check("nom_dp_low", 32'(bus.datapath_rst_n_o), 32'h0);
    tick();
    check("nom_dp_rise", 32'({bus.datapath_rst_n_o, bus.rst_done_o}), 32'h2);
    tick();
    check("nom_done_rise", 32'(bus.rst_done_o), 32'h1);
    check("nom_retry", 32'(bus.retry_count_o), 32'h0);

    // Partial lanes: 1 and 3 disabled and never done.
    soft_pulse();
    bus.lane_enable_i = 4'b0101;
    stuck_tx = 4'b1010;
    wait_state(3, 30, "part_wait_gt");
    check("part_gt", 32'(bus.gt_rst_n_o), 32'h5);
    wait_state(5, 40, "part_done");
    check("part_fault", 32'(bus.lane_fault_o), 32'h0);

    // Timeout and retry: lane 2 rx never done.
    soft_pulse();
    bus.lane_enable_i = '1;
    stuck_tx = '0;
    stuck_rx = 4'b0100;
    wait_state(3, 30, "to_wait_gt");
    repeat (TO - 1) tick();
    check("to_still_wait", 32'(bus.state_o), 32'd3);
    tick();
    check("to_fault", 32'(bus.lane_fault_o), 32'h4);
    check("to_retry", 32'(bus.retry_count_o), 32'd1);
    check("to_gt", 32'(bus.gt_rst_n_o), 32'h0);
    wait_state(6, 200, "to_fail");
    check("to_fail_flag", 32'(bus.rst_fail_o), 32'h1);
    check("to_fail_retry", 32'(bus.retry_count_o), 32'd2);
    check("to_fail_fault", 32'(bus.lane_fault_o), 32'h4);

    // Soft reset out of FAIL.
    stuck_rx = '0;
    soft_pulse();
    check("soft_state0", 32'(bus.state_o), 32'd0);
    check("soft_clear", 32'({bus.rst_fail_o, bus.retry_count_o, bus.lane_fault_o}), 32'h0);
    tick();
    check("soft_state1", 32'(bus.state_o), 32'd1);

    // In-service drop of lane 0.
    wait_state(5, 60, "drop_pre_done");
    tick();
    bus.gt_tx_rst_done_i[0] = 1'b0;
    tick();
    check("drop_dp", 32'({bus.datapath_rst_n_o, bus.rst_done_o}), 32'h0);
    check("drop_fault", 32'(bus.lane_fault_o), 32'h1);
    check("drop_retry", 32'(bus.retry_count_o), 32'd1);
    wait_state(5, 60, "drop_rebring");
    tick();
    check("drop_done", 32'(bus.rst_done_o), 32'h1);

    // Second drop, then power-good loss in DP_DELAY keeps retry count.
    bus.gt_tx_rst_done_i[1] = 1'b0;
    tick();
    wait_state(4, 60, "pg_dp_delay");
    bus.gt_power_good_i = 1'b0;
    tick();
    check("pg_state", 32'(bus.state_o), 32'd1);
    check("pg_resets", 32'({bus.gt_rst_n_o, bus.datapath_rst_n_o, bus.rst_done_o}), 32'h0);
    check("pg_retry", 32'(bus.retry_count_o), 32'd2);
    repeat (3) tick();
    bus.gt_power_good_i = 1'b1;
    wait_state(5, 60, "pg_resume");

    // Hard reset in the middle of GT_DELAY.
    soft_pulse();
    wait_state(2, 10, "hr_gt_delay");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("hard_rst", dut_vec(), 32'h0);
    rst_n = 1'b1;

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) bus.gt_power_good_i = ~bus.gt_power_good_i;
      if (!bus.gt_power_good_i && $urandom_range(9) == 0) bus.gt_power_good_i = 1'b1;
      bus.lane_enable_i  = NL'($urandom);
      bus.soft_rst_req_i = ($urandom_range(399) == 0);
      rst_n              = ($urandom_range(999) != 0);
      if ($urandom_range(149) == 0) stuck_rx = ($urandom_range(3) == 0) ? NL'($urandom) : '0;
      if ($urandom_range(149) == 0) stuck_tx = ($urandom_range(3) == 0) ? NL'($urandom) : '0;
      if ($urandom_range(99) == 0) lat[$urandom_range(NL - 1)] = $urandom_range(1, 8);
      if ($urandom_range(119) == 0) bus.gt_tx_rst_done_i[$urandom_range(NL - 1)] = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
